// File: rtl/pipelined_limb_addsub.sv
// Skewed limb-serial adder/subtractor: the carry/borrow moves one LW-bit limb per stage, and a new op is accepted every clock.
// Defining PIPELINED_LIMB_ADDSUB_MODRED_EN adds a final stage that reduces the result modulo MODULUS.
module pipelined_limb_addsub #(
  parameter int W = 256,
  parameter int LIMBS = 4,
  parameter logic [W-1:0] MODULUS = 256'h2523648240000001ba344d80000000086121000000000013a700000000000013
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         in_valid,
  input  logic         sub,
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  output logic         out_valid,
  output logic [W-1:0] Z,
  output logic         cout
);

  localparam int LW = W / LIMBS;

  if (LIMBS < 1) begin : g_bad_limbs
    $error("pipelined_limb_addsub: LIMBS must be >= 1");
  end
  if (W % LIMBS != 0) begin : g_bad_width
    $error("pipelined_limb_addsub: W must be a multiple of LIMBS");
  end
  if (MODULUS == '0) begin : g_bad_modulus
    $error("pipelined_limb_addsub: MODULUS must be nonzero");
  end

  // Handshake: an op is taken on a rising edge with ce=1 and in_valid=1. out_valid stays high for
  // exactly one enabled cycle per op. There is no backpressure, and ce=0 freezes the whole pipe.
  // Stage k holds result limbs 0..k, the unconsumed upper operand limbs and the carry into limb k+1.
  // Y is inverted on entry in sub mode, so every stage only adds.
  for (genvar k = 0; k < LIMBS; k++) begin : g_stage
    localparam int IW = (LIMBS - k) * LW;

    logic                  s_valid, s_sub, s_cin;
    logic [IW-1:0]         s_x, s_y;
    logic [LW:0]           sum;
    logic [(k+1)*LW-1:0]   z_new;
    logic                  valid_d, valid_q, sub_d, sub_q, c_d, c_q;
    logic [(k+1)*LW-1:0]   z_d, z_q;

    if (k == 0) begin : g_src
      always_comb begin
        s_valid = in_valid;
        s_sub   = sub;
        s_cin   = sub;
        s_x     = X;
        s_y     = sub ? ~Y : Y;
        z_new   = sum[LW-1:0];
      end
    end else begin : g_src
      always_comb begin
        s_valid = g_stage[k-1].valid_q;
        s_sub   = g_stage[k-1].sub_q;
        s_cin   = g_stage[k-1].c_q;
        s_x     = g_stage[k-1].g_ops.x_q;
        s_y     = g_stage[k-1].g_ops.y_q;
        z_new   = {sum[LW-1:0], g_stage[k-1].z_q};
      end
    end

    // Data registers only load on a valid op, so bubbles leave the last result in place.
    always_comb begin
      sum     = {1'b0, s_x[LW-1:0]} + {1'b0, s_y[LW-1:0]} + {{LW{1'b0}}, s_cin};
      valid_d = s_valid;
      sub_d   = sub_q;
      c_d     = c_q;
      z_d     = z_q;
      if (s_valid) begin
        sub_d = s_sub;
        c_d   = sum[LW];
        z_d   = z_new;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        sub_q   <= 1'b0;
        c_q     <= 1'b0;
        z_q     <= '0;
      end else if (ce) begin
        valid_q <= valid_d;
        sub_q   <= sub_d;
        c_q     <= c_d;
        z_q     <= z_d;
      end
    end

    if (k < LIMBS - 1) begin : g_ops
      logic [IW-LW-1:0] x_d, x_q, y_d, y_q;

      always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (s_valid) begin
          x_d = s_x[IW-1:LW];
          y_d = s_y[IW-1:LW];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_q <= '0;
          y_q <= '0;
        end else if (ce) begin
          x_q <= x_d;
          y_q <= y_d;
        end
      end
    end
  end

  logic         raw_valid, raw_sub, raw_c;
  logic [W-1:0] raw_z;

  assign raw_valid = g_stage[LIMBS-1].valid_q;
  assign raw_sub   = g_stage[LIMBS-1].sub_q;
  assign raw_c     = g_stage[LIMBS-1].c_q;
  assign raw_z     = g_stage[LIMBS-1].z_q;

`ifdef PIPELINED_LIMB_ADDSUB_MODRED_EN
  logic [W-1:0] z_minus, z_plus, z_d, z_q;
  logic         cout_d, cout_q, out_valid_d, out_valid_q;

  // In add mode raw_c is the 2^W bit of the sum. In sub mode raw_c=0 means X<Y.
  always_comb begin
    z_minus     = raw_z - MODULUS;
    z_plus      = raw_z + MODULUS;
    out_valid_d = raw_valid;
    z_d         = z_q;
    cout_d      = cout_q;
    if (raw_valid) begin
      if (!raw_sub) begin
        if ({raw_c, raw_z} >= {1'b0, MODULUS}) begin
          z_d    = z_minus;
          cout_d = 1'b1;
        end else begin
          z_d    = raw_z;
          cout_d = 1'b0;
        end
      end else begin
        if (!raw_c) begin
          z_d    = z_plus;
          cout_d = 1'b1;
        end else begin
          z_d    = raw_z;
          cout_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      z_q         <= '0;
      cout_q      <= 1'b0;
    end else if (ce) begin
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
      cout_q      <= cout_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Z         = z_q;
  assign cout      = cout_q;
`else
  assign out_valid = raw_valid;
  assign Z         = raw_z;
  assign cout      = raw_c ^ raw_sub;
`endif

endmodule

// File: tb/tb_pipelined_limb_addsub.sv
// Scoreboard bench for pipelined_limb_addsub: accepted ops push golden results, and the output monitor pops and checks them in order.
// Follows PIPELINED_LIMB_ADDSUB_MODRED_EN for the expected latency and reduction.
module tb_pipelined_limb_addsub;
  localparam int W = 256;
  localparam int LIMBS = 4;
  localparam logic [W-1:0] MOD = 256'h2523648240000001ba344d80000000086121000000000013a700000000000013;
`ifdef PIPELINED_LIMB_ADDSUB_MODRED_EN
  localparam int LAT = LIMBS + 1;
  localparam bit MODRED = 1'b1;
`else
  localparam int LAT = LIMBS;
  localparam bit MODRED = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ce = 1'b0;
  logic         in_valid = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] X = '0;
  logic [W-1:0] Y = '0;
  logic         out_valid;
  logic [W-1:0] Z;
  logic         cout;

  pipelined_limb_addsub #(.W(W), .LIMBS(LIMBS), .MODULUS(MOD)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .sub(sub),
    .X(X), .Y(Y), .out_valid(out_valid), .Z(Z), .cout(cout)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int           total = 0;
  int           bad = 0;
  logic [W:0]   exp_q[$];
  int           acc_q[$];
  int           en_cnt = 0;
  int           acc_total = 0;
  int           out_total = 0;
  logic [W-1:0] last_z = '0;
  logic         last_c = 1'b0;

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W:0] r;
    if (!s) r = {1'b0, a} + {1'b0, b};
    else    r = {(a < b), a - b};
    if (MODRED) begin
      if (!s) begin
        if (r >= {1'b0, MOD}) r = {1'b1, W'(r - {1'b0, MOD})};
        else                  r = {1'b0, r[W-1:0]};
      end else begin
        if (a < b) r = {1'b1, a - b + MOD};
        else       r = {1'b0, a - b};
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin : monitor
    logic       ce_s, rst_s;
    logic [W:0] e;
    int         a;
    rst_s = rst_n;
    ce_s  = ce;
    if (!rst_s) begin
      exp_q.delete();
      acc_q.delete();
      last_z = '0;
      last_c = 1'b0;
    end else if (ce_s) begin
      en_cnt++;
      if (in_valid) begin
        exp_q.push_back(model(X, Y, sub));
        acc_q.push_back(en_cnt);
        acc_total++;
      end
    end
    #2;
    if (rst_s && ce_s) begin
      if (out_valid) begin
        out_total++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_result: got Z=%h cout=%b, required no output", Z, cout);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          total++;
          if (Z !== e[W-1:0]) begin
            bad++;
            $display("FAIL z: got %h required %h", Z, e[W-1:0]);
          end
          total++;
          if (cout !== e[W]) begin
            bad++;
            $display("FAIL cout: got %b required %b", cout, e[W]);
          end
          total++;
          if (en_cnt - a + 1 != LAT) begin
            bad++;
            $display("FAIL latency: got %0d required %0d", en_cnt - a + 1, LAT);
          end
          last_z = Z;
          last_c = cout;
        end
      end else begin
        total++;
        if (Z !== last_z || cout !== last_c) begin
          bad++;
          $display("FAIL hold: got Z=%h cout=%b required Z=%h cout=%b", Z, cout, last_z, last_c);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 3))
      0: r = '1 - W'($urandom_range(0, 3));
      1: r = W'($urandom_range(0, 7));
      default: ;
    endcase
    if (MODRED) r = r % MOD;
    return r;
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    ce = 1'b1;
    X = a;
    Y = b;
    sub = s;
    in_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    ce = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) idle(1);
    idle(2);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending results, required 0", exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    ce = 1'b1;
    in_valid = 1'b1;
    X = rand_w();
    Y = rand_w();
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    total++;
    if (Z !== '0) begin bad++; $display("FAIL reset_z: got %h required 0", Z); end
    total++;
    if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b required 0", cout); end
    rst_n = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_carry();
`ifdef PIPELINED_LIMB_ADDSUB_MODRED_EN
    drive(MOD - 1, 1, 1'b0);
    drive('0, 1, 1'b1);
    drive(MOD - 1, MOD - 1, 1'b0);
`else
    drive('1, 1, 1'b0);
    drive('1, '1, 1'b0);
`endif
    idle(1);
    drain();
  endtask

  task automatic test_borrow();
    drive('0, 1, 1'b1);
    drive(5, 3, 1'b1);
    drive('0, '0, 1'b1);
    drive(3, 5, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) drive(rand_w(), rand_w(), 1'($urandom_range(0, 1)));
    drain();
  endtask

  task automatic test_random();
    int a0, o0, n;
    a0 = acc_total;
    o0 = out_total;
    n = 0;
    for (int i = 0; i < 2000 && n < 100; i++) begin
      @(negedge clk);
      ce = ($urandom_range(0, 3) != 0);
      in_valid = ($urandom_range(0, 2) != 0);
      X = rand_w();
      Y = rand_w();
      sub = 1'($urandom_range(0, 1));
      if (ce && in_valid) n++;
    end
    idle(1);
    drain();
    total++;
    if (acc_total - a0 != 100) begin
      bad++;
      $display("FAIL random_in_count: got %0d accepted required 100", acc_total - a0);
    end
    total++;
    if (out_total - o0 != acc_total - a0) begin
      bad++;
      $display("FAIL random_out_count: got %0d results required %0d", out_total - o0, acc_total - a0);
    end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < LIMBS - 1; i++) drive(rand_w(), rand_w(), 1'($urandom_range(0, 1)));
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midflight_out_valid: got %b required 0", out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(LAT + 2);
    drive(9, 4, 1'b1);
    drive(rand_w(), rand_w(), 1'b0);
    idle(1);
    drain();
  endtask

  initial begin
    test_reset();
    test_carry();
    test_borrow();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
